pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WDT_LIMIT, default 64: consecutive EXHOLD cycles before watchdog action (Configuration only).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 id_reg1_read_i  in  1  ID stage reads source port 1.
REQ-005 id_reg1_addr_i  in  5  ID source address 1.
REQ-006 id_reg2_read_i  in  1  ID stage reads source port 2.
REQ-007 id_reg2_addr_i  in  5  ID source address 2.
REQ-008 ex_is_load_i  in  1  instruction in EX is a load.
REQ-009 ex_wreg_i  in  1  EX instruction writes a register.
REQ-010 ex_wd_i  in  5  EX destination address.
REQ-011 ex_stallreq_i  in  1  multi-cycle EX op busy (level, held until done).
REQ-012 flush_req_i  in  1  exception/redirect flush request (pulse or level).
REQ-013 stall_o  out  6  stage hold vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-014 flush_o  out  1  clear IF/ID and ID/EX pipeline registers.
REQ-015 hold_cnt_o  out  8  consecutive EXHOLD cycles, registered.
REQ-016 wdt_err_o  out  1  sticky watchdog error flag.

Function
REQ-017 Load-use hazard = ex_is_load_i & ex_wreg_i & (ex_wd_i != 0) & ((id_reg1_read_i & id_reg1_addr_i == ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i == ex_wd_i)); combinational.
REQ-018 FSM states: RUN, LOADUSE, EXHOLD, FLUSH1; state register updates on clk.
REQ-019 stall_o/flush_o are Mealy outputs of current state and current inputs (zero-cycle latency), priority flush > ex_stallreq > load-use.
REQ-020 flush_req_i=1 (any state): stall_o=000000, flush_o=1, next state FLUSH1.
REQ-021 FLUSH1 with flush_req_i=0: flush_o=1, stall_o=000000, next RUN (two flush cycles total); flush_req_i=1 in FLUSH1 restarts per REQ-020.
REQ-022 Else ex_stallreq_i=1: stall_o=001111, flush_o=0, next EXHOLD.
REQ-023 EXHOLD with ex_stallreq_i=0: stall_o=000000, next RUN; load-use in that cycle evaluated per REQ-024.
REQ-024 Else load-use=1: stall_o=000111, flush_o=0, next LOADUSE; LOADUSE lasts one cycle then RUN unless a higher-priority event applies.
REQ-025 No event: stall_o=000000, flush_o=0, next RUN.
REQ-026 hold_cnt_o increments each cycle the next state is EXHOLD, saturates at 255, clears to 0 on any transition out of EXHOLD.
REQ-027 Never stall_o != 0 and flush_o=1 in the same cycle.

Reset
REQ-028 rst=1 at a clock edge: state RUN, hold_cnt_o=0, wdt_err_o=0; outputs stall_o=000000, flush_o=0 while rst=1, overriding all inputs.
REQ-029 Reset mid-EXHOLD or mid-FLUSH1 abandons the sequence; no residual flush/stall cycle after rst deasserts.

Configuration
REQ-030 Macro PIPE_CTRL_WDT_EN defined: when hold_cnt_o reaches WDT_LIMIT in EXHOLD, that cycle drives flush per REQ-020 regardless of ex_stallreq_i and sets wdt_err_o=1 until reset.
REQ-031 Macro undefined: no watchdog logic, wdt_err_o tied 0, EXHOLD lasts as long as ex_stallreq_i.

Verification
REQ-032 ex_is_load_i=1, ex_wreg_i=1, ex_wd_i=5, id_reg2_read_i=1, id_reg2_addr_i=5 -> stall_o=000111 same cycle, one cycle only, then 000000.
REQ-033 Same as REQ-032 but ex_wd_i=0 -> stall_o=000000 (r0 never hazards).
REQ-034 ex_stallreq_i high 10 cycles -> stall_o=001111 for 10 cycles, hold_cnt_o 1..10, then 0 and stall_o=000000.
REQ-035 flush_req_i and ex_stallreq_i high same cycle -> flush_o=1, stall_o=0 for 2 cycles, then EXHOLD resumes if ex_stallreq_i still high.
REQ-036 PIPE_CTRL_WDT_EN, WDT_LIMIT=4, ex_stallreq_i stuck high -> 4 hold cycles, then flush_o=1 and wdt_err_o=1 sticky until rst.
REQ-037 rst pulsed during EXHOLD (cnt=7) -> next cycle stall_o=0, hold_cnt_o=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline hazard/stall/flush controller for a 6-stage in-order
//            core. Detects load-use hazards, holds the front end while a
//            multi-cycle EX op is busy, and issues two-cycle flushes.
//            stall_o/flush_o are Mealy outputs (same-cycle response).
// Ports    : clk, rst (sync, active-high)
//            id_reg{1,2}_read_i/_addr_i : ID-stage source operand usage
//            ex_is_load_i, ex_wreg_i, ex_wd_i : EX-stage destination info
//            ex_stallreq_i : multi-cycle EX busy (level)
//            flush_req_i   : exception/redirect flush request
//            stall_o[5:0]  : hold vector {WB,MEM,EX,ID,IF,PC}
//            flush_o       : clear IF/ID and ID/EX registers
//            hold_cnt_o    : consecutive EXHOLD cycles (saturating at 255)
//            wdt_err_o     : sticky watchdog error
// Options  : define PIPE_CTRL_WDT_EN to enable the EXHOLD watchdog
//            (threshold set by parameter WDT_LIMIT).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int WDT_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_reg1_read_i,
  input  logic [4:0] id_reg1_addr_i,
  input  logic       id_reg2_read_i,
  input  logic [4:0] id_reg2_addr_i,
  input  logic       ex_is_load_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_wd_i,
  input  logic       ex_stallreq_i,
  input  logic       flush_req_i,
  output logic [5:0] stall_o,
  output logic       flush_o,
  output logic [7:0] hold_cnt_o,
  output logic       wdt_err_o
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LOADUSE = 2'd1,
    S_EXHOLD  = 2'd2,
    S_FLUSH1  = 2'd3
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_EX   = 6'b001111;  // PC, IF, ID, EX held
  localparam logic [5:0] STALL_LU   = 6'b000111;  // PC, IF, ID held; bubble into EX

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [5:0] stall_d;
  logic       flush_d;
  logic       load_use;
  logic       wdt_fire;

  // r0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_is_load_i & ex_wreg_i & (ex_wd_i != 5'd0) &
                    ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
                     (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));

`ifdef PIPE_CTRL_WDT_EN
  logic wdt_err_q, wdt_err_d;

  // Fires in the EXHOLD cycle where the count has reached the limit; that
  // cycle is converted into a flush instead of another hold.
  assign wdt_fire  = (state_q == S_EXHOLD) && (hold_cnt_q == 8'(WDT_LIMIT));
  assign wdt_err_d = wdt_err_q | wdt_fire;
  assign wdt_err_o = wdt_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_err_q <= 1'b0;
    end else begin
      wdt_err_q <= wdt_err_d;
    end
  end
`else
  // WDT_LIMIT stays in the interface so both builds share one instantiation;
  // without the watchdog it has no effect and this term folds to zero.
  assign wdt_fire  = 1'b0 && (hold_cnt_q == 8'(WDT_LIMIT));
  assign wdt_err_o = 1'b0;
`endif

  always_comb begin
    stall_d    = STALL_NONE;
    flush_d    = 1'b0;
    state_d    = S_RUN;
    hold_cnt_d = 8'd0;

    if (flush_req_i || wdt_fire) begin
      flush_d = 1'b1;
      state_d = S_FLUSH1;
    end else if (state_q == S_FLUSH1) begin
      // Second flush cycle: flush has priority over any pending stall.
      flush_d = 1'b1;
      state_d = S_RUN;
    end else if (ex_stallreq_i) begin
      stall_d    = STALL_EX;
      state_d    = S_EXHOLD;
      hold_cnt_d = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
    end else if (load_use && (state_q != S_LOADUSE)) begin
      // The hazard inputs still describe the pre-bubble EX instruction in
      // LOADUSE, so a hazard is only honoured on entry.
      stall_d = STALL_LU;
      state_d = S_LOADUSE;
    end

    // Reset forces quiet outputs regardless of inputs or current state.
    if (rst) begin
      stall_d = STALL_NONE;
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign stall_o    = stall_d;
  assign flush_o    = flush_d;
  assign hold_cnt_o = hold_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed self-checking bench for pipe_ctrl. Watchdog scenario is
//            compiled in when PIPE_CTRL_WDT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_reg1_read_i;
  logic [4:0] id_reg1_addr_i;
  logic       id_reg2_read_i;
  logic [4:0] id_reg2_addr_i;
  logic       ex_is_load_i;
  logic       ex_wreg_i;
  logic [4:0] ex_wd_i;
  logic       ex_stallreq_i;
  logic       flush_req_i;
  logic [5:0] stall_o;
  logic       flush_o;
  logic [7:0] hold_cnt_o;
  logic       wdt_err_o;

  int nvec = 0;
  int nerr = 0;

  pipe_ctrl #(.WDT_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_stallreq_i  (ex_stallreq_i),
    .flush_req_i    (flush_req_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .hold_cnt_o     (hold_cnt_o),
    .wdt_err_o      (wdt_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
    id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;
    ex_is_load_i   = 1'b0; ex_wreg_i      = 1'b0; ex_wd_i = 5'd0;
    ex_stallreq_i  = 1'b0; flush_req_i    = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset must override an active flush request and stall request.
    flush_req_i   = 1'b1;
    ex_stallreq_i = 1'b1;
    tick(); tick();
    chk("rst_stall", {2'b0, stall_o}, 8'h00);
    chk("rst_flush", {7'b0, flush_o}, 8'h00);
    chk("rst_cnt",   hold_cnt_o,      8'h00);
    chk("rst_wdt",   {7'b0, wdt_err_o}, 8'h00);
    clear_inputs();
    rst = 1'b0;
    tick();
    chk("idle_stall", {2'b0, stall_o}, 8'h00);

    // Load-use via source port 2, held inputs: one stall cycle only.
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd5;
    id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd5;
    #1;
    chk("lu_stall",  {2'b0, stall_o}, 8'h07);
    chk("lu_flush",  {7'b0, flush_o}, 8'h00);
    tick();
    chk("lu_once",   {2'b0, stall_o}, 8'h00);
    clear_inputs();
    tick();

    // r0 destination never hazards.
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd0;
    id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd0;
    #1;
    chk("lu_r0", {2'b0, stall_o}, 8'h00);

    // Port 1 match but not read: no hazard; then read asserted: hazard.
    clear_inputs();
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd17;
    id_reg1_addr_i = 5'd17;
    #1;
    chk("lu_noread", {2'b0, stall_o}, 8'h00);
    id_reg1_read_i = 1'b1;
    #1;
    chk("lu_port1", {2'b0, stall_o}, 8'h07);
    // Non-load producer: no hazard.
    ex_is_load_i = 1'b0;
    #1;
    chk("lu_notload", {2'b0, stall_o}, 8'h00);
    clear_inputs();
    tick();

`ifndef PIPE_CTRL_WDT_EN
    // Multi-cycle EX op for 10 cycles.
    ex_stallreq_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("exh_stall_%0d", i), {2'b0, stall_o}, 8'h0F);
      tick();
      chk($sformatf("exh_cnt_%0d", i), hold_cnt_o, 8'(i));
    end
    ex_stallreq_i = 1'b0;
    #1;
    chk("exh_release", {2'b0, stall_o}, 8'h00);
    tick();
    chk("exh_cnt_clr", hold_cnt_o, 8'h00);

    // Long hold saturates the counter.
    ex_stallreq_i = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("exh_sat", hold_cnt_o, 8'hFF);
    ex_stallreq_i = 1'b0;
    tick();
    chk("exh_sat_clr", hold_cnt_o, 8'h00);
`endif

    // Flush and stall requested together: two flush cycles, then EXHOLD.
    flush_req_i = 1'b1; ex_stallreq_i = 1'b1;
    #1;
    chk("fl1_flush", {7'b0, flush_o}, 8'h01);
    chk("fl1_stall", {2'b0, stall_o}, 8'h00);
    tick();
    flush_req_i = 1'b0;
    #1;
    chk("fl2_flush", {7'b0, flush_o}, 8'h01);
    chk("fl2_stall", {2'b0, stall_o}, 8'h00);
    tick();
    chk("fl_done_flush", {7'b0, flush_o}, 8'h00);
    chk("fl_resume",     {2'b0, stall_o}, 8'h0F);
    tick();
    chk("fl_resume_cnt", hold_cnt_o, 8'h01);

    // Reset mid-EXHOLD at count 3 (watchdog limit safe) / 7 otherwise.
`ifdef PIPE_CTRL_WDT_EN
    tick(); tick();
    chk("pre_rst_cnt", hold_cnt_o, 8'h03);
`else
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_cnt", hold_cnt_o, 8'h07);
`endif
    rst = 1'b1;
    #1;
    chk("rst_exh_stall", {2'b0, stall_o}, 8'h00);
    tick();
    rst = 1'b0; ex_stallreq_i = 1'b0;
    #1;
    chk("post_rst_cnt",   hold_cnt_o, 8'h00);
    chk("post_rst_stall", {2'b0, stall_o}, 8'h00);
    chk("post_rst_flush", {7'b0, flush_o}, 8'h00);
    // State is RUN: a fresh hazard is accepted immediately.
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd9;
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd9;
    #1;
    chk("post_rst_run", {2'b0, stall_o}, 8'h07);
    clear_inputs();
    tick();

    // Reset mid-FLUSH1: no residual flush cycle.
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0; rst = 1'b1;
    #1;
    chk("rst_fl1_flush", {7'b0, flush_o}, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    chk("post_fl_rst_flush", {7'b0, flush_o}, 8'h00);
    tick();

`ifdef PIPE_CTRL_WDT_EN
    // Stuck EX op: 4 hold cycles, then watchdog flush and sticky error.
    ex_stallreq_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("wdt_hold_%0d", i), {2'b0, stall_o}, 8'h0F);
      tick();
      chk($sformatf("wdt_cnt_%0d", i), hold_cnt_o, 8'(i));
    end
    chk("wdt_fire_flush", {7'b0, flush_o}, 8'h01);
    chk("wdt_fire_stall", {2'b0, stall_o}, 8'h00);
    chk("wdt_pre_err",    {7'b0, wdt_err_o}, 8'h00);
    tick();
    chk("wdt_fl2_flush", {7'b0, flush_o}, 8'h01);
    chk("wdt_err_set",   {7'b0, wdt_err_o}, 8'h01);
    chk("wdt_cnt_clr",   hold_cnt_o, 8'h00);
    tick();
    chk("wdt_rehold", {2'b0, stall_o}, 8'h0F);
    chk("wdt_sticky", {7'b0, wdt_err_o}, 8'h01);
    ex_stallreq_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("wdt_err_rst", {7'b0, wdt_err_o}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
